wb_master_pipelined: RTL and testbench
======================================

WB_MASTER_PIPELINED -- requirements
Module: wb_master_pipelined

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, giving the maximum accepted-but-unacknowledged requests (range 1..15).
REQ-002 SHALL have parameter LEN_W, default 8, giving the width of the command transfer count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port wb, interface if_wb.master: Wishbone B4 pipelined master port, using adr, dat_o, dat_i, we, cyc, stb, ack and stall.
REQ-006 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-007 SHALL have port cmd_ready, output, 1 bit: the block accepts a command.
REQ-008 SHALL have port cmd_we, input, 1 bit: 1 selects a write burst, 0 a read burst.
REQ-009 SHALL have port cmd_adr, input, width of wb.adr: start word address.
REQ-010 SHALL have port cmd_len, input, LEN_W bits: number of transfers; 0 is legal.
REQ-011 SHALL have ports wdat_valid (input, 1), wdat_ready (output, 1) and wdat (input, width of wb.dat_o): the write-data stream.
REQ-012 SHALL have ports rdat_valid (output, 1) and rdat (output, width of wb.dat_i): the read-data stream, with no backpressure.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on burst completion.

Function
REQ-014 SHALL implement an FSM with states IDLE, ISSUE and DRAIN.
REQ-015 SHALL assert cmd_ready only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1.
REQ-016 SHALL, on acceptance with cmd_len=0, stay in IDLE, pulse done the next cycle, and leave cyc and stb low.
REQ-017 SHALL, on acceptance with cmd_len>0, latch we, adr and len, go to ISSUE, and assert cyc and stb in the next cycle (one-cycle latency).
REQ-018 SHALL count a request as accepted only in a cycle where stb=1 and stall=0.
REQ-019 SHALL hold adr, dat_o and we stable while stb=1 and stall=1.
REQ-020 SHALL increment adr by 1, modulo 2^width, per accepted request.
REQ-021 SHALL deassert stb when the outstanding count equals MAX_OUTSTANDING, and for writes also when wdat_valid=0.
REQ-022 SHALL drive wdat_ready = stb & ~stall & we, so that wdat is consumed exactly on request acceptance; dat_o = wdat.
REQ-023 SHALL maintain an outstanding count: +1 on acceptance, -1 on ack, unchanged when both occur in the same cycle.
REQ-024 SHALL ignore an ack while outstanding=0 (no underflow, no rdat_valid).
REQ-025 SHALL, on an ack during a read burst, drive rdat_valid=1 and rdat=wb.dat_i in the same cycle (combinational pass-through).
REQ-026 SHALL go from ISSUE to DRAIN after the last request is accepted, with stb low in DRAIN.
REQ-027 SHALL, on the ack that brings outstanding to 0 in DRAIN, deassert cyc the next cycle, pulse done for one cycle, and return to IDLE; a new command may be accepted in the cycle after done.
REQ-028 SHALL keep cyc high continuously from the first stb to the last ack.
REQ-029 SHALL remain correct when connected to a standard slave through the pipelined-to-standard adapter (stall = cyc & ~ack), which limits it to one request per ack.

Reset
REQ-030 SHALL, while rst=0, asynchronously force: FSM=IDLE; cyc, stb, we, done, rdat_valid=0; adr=0; outstanding=0; cmd_ready=0.
REQ-031 SHALL, when reset is asserted mid-burst, drop cyc and stb immediately and discard pending acks; after release, start in IDLE with cmd_ready=1.

Structure
REQ-032 SHALL take the FSM state enum and the outstanding-counter width ($clog2(MAX_OUTSTANDING+1)) from a shared package, wb_pkg.
REQ-033 SHALL implement the counter as sub-module wb_outstanding_cnt (inc, dec, count, full, empty); everything else stays in one module.

Verification
REQ-034 Bench SHALL cover: read, adr=0x10, len=4, zero-wait pipelined slave acking one cycle after each request -> stb accepted 4 consecutive cycles, adr 0x10..0x13, 4 rdat_valid pulses, one done, cyc high for 5 cycles.
REQ-035 Bench SHALL cover: write, len=3, stall high for 2 cycles on the first request -> adr and dat_o stay stable, wdat_ready=0 while stalled, 3 words written in order.
REQ-036 Bench SHALL cover: MAX_OUTSTANDING=2, slave withholds ack for 5 cycles -> stb drops after 2 accepts, outstanding never exceeds 2.
REQ-037 Bench SHALL cover: cmd_len=0 -> no cyc, done pulses one cycle after acceptance.
REQ-038 Bench SHALL cover: adr=all-ones, len=2 -> second request at adr=0.
REQ-039 Bench SHALL cover: rst=0 asserted during a read burst of len=8 -> cyc and stb low the same cycle; after release a fresh len=1 read completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the pipelined Wishbone master: FSM state encoding and the
// sizing rule for the outstanding-request counter.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } wb_state_e;

    localparam int DEF_MAX_OUTSTANDING = 4;

    // Counter must represent 0..max_out inclusive.
    function automatic int outstanding_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/if_wb.sv
// Wishbone B4 pipelined bus bundle with master and slave views.
interface if_wb #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
);
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_o;
    logic [DAT_W-1:0] dat_i;
    logic             we;
    logic             cyc;
    logic             stb;
    logic             ack;
    logic             stall;

    modport master (
        output adr, dat_o, we, cyc, stb,
        input  dat_i, ack, stall
    );

    modport slave (
        input  adr, dat_o, we, cyc, stb,
        output dat_i, ack, stall
    );
endinterface

// File: rtl/wb_outstanding_cnt.sv
// Up/down counter of accepted-but-unacknowledged requests; a decrement
// with nothing outstanding is dropped so the count never underflows.
module wb_outstanding_cnt
    import wb_pkg::*;
#(
    parameter int MAX = DEF_MAX_OUTSTANDING,
    parameter int W   = outstanding_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         empty
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign full  = (count == W'(MAX));
    assign empty = (count == '0);

endmodule

// File: rtl/wb_master_pipelined.sv
// Burst master for a Wishbone B4 pipelined bus: turns one command into
// cmd_len single-word requests with up to MAX_OUTSTANDING in flight.
module wb_master_pipelined
    import wb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int LEN_W           = 8,
    parameter int ADR_W           = 32,
    parameter int DAT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    if_wb.master             wb,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wdat_valid,
    output logic             wdat_ready,
    input  logic [DAT_W-1:0] wdat,
    output logic             rdat_valid,
    output logic [DAT_W-1:0] rdat,
    output logic             done,
    output wb_state_e        state
);

    localparam int CNT_W = outstanding_w(MAX_OUTSTANDING);

    logic             we_q;
    logic [ADR_W-1:0] adr_q;
    logic [LEN_W-1:0] rem_q;
    logic             cyc_q;

    logic             cmd_fire;
    logic             stb;
    logic             req_acc;
    logic             ack_ok;
    logic             last_req;
    logic             drain_end;

    logic [CNT_W-1:0] cnt_count;
    logic             cnt_full;
    logic             cnt_empty;

    // Handshakes: a command transfers when cmd_valid & cmd_ready; a bus
    // request transfers when stb & ~stall; a write word transfers with it.
    // cmd_ready is held low during the done cycle so a new burst starts after.
    assign cmd_ready = rst & (state == ST_IDLE) & ~done;
    assign cmd_fire  = cmd_valid & cmd_ready;

    assign stb      = (state == ST_ISSUE) & ~cnt_full & (~we_q | wdat_valid);
    assign req_acc  = stb & ~wb.stall;
    assign last_req = req_acc & (rem_q == LEN_W'(1));

    // An ack arriving with its own request (standard-slave adapter) is
    // still a real ack even though nothing was outstanding before it.
    assign ack_ok    = wb.ack & (state != ST_IDLE) & (~cnt_empty | req_acc);
    assign drain_end = (state == ST_DRAIN) & ack_ok & (cnt_count == CNT_W'(1));

    assign wb.adr   = adr_q;
    assign wb.dat_o = wdat;
    assign wb.we    = we_q;
    assign wb.cyc   = cyc_q;
    assign wb.stb   = stb;

    assign wdat_ready = stb & ~wb.stall & we_q;
    assign rdat_valid = ack_ok & ~we_q;
    assign rdat       = wb.dat_i;

    wb_outstanding_cnt #(
        .MAX (MAX_OUTSTANDING),
        .W   (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (req_acc),
        .dec   (ack_ok),
        .count (cnt_count),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            rem_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            we_q  <= cmd_we;
                            adr_q <= cmd_adr;
                            rem_q <= cmd_len;
                            cyc_q <= 1'b1;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (req_acc) begin
                        adr_q <= adr_q + 1'b1;
                        rem_q <= rem_q - 1'b1;
                        if (last_req) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_end) begin
                        cyc_q <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_pipelined.sv
// Directed bench for wb_master_pipelined: a bus/slave model answers requests,
// a negedge monitor checks every request and read word against queued values.
module tb_wb_master_pipelined;
    import wb_pkg::*;

    localparam int MAXO  = 2;
    localparam int LEN_W = 8;
    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam logic [DAT_W-1:0] RD_KEY = 32'hA5A5_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [ADR_W-1:0] cmd_adr;
    logic [LEN_W-1:0] cmd_len;
    logic             wdat_valid;
    logic             wdat_ready;
    logic [DAT_W-1:0] wdat;
    logic             rdat_valid;
    logic [DAT_W-1:0] rdat;
    logic             done;
    wb_state_e        state;

    if_wb #(.ADR_W(ADR_W), .DAT_W(DAT_W)) wb_bus ();

    wb_master_pipelined #(
        .MAX_OUTSTANDING (MAXO),
        .LEN_W           (LEN_W),
        .ADR_W           (ADR_W),
        .DAT_W           (DAT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb         (wb_bus),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .wdat_valid (wdat_valid),
        .wdat_ready (wdat_ready),
        .wdat       (wdat),
        .rdat_valid (rdat_valid),
        .rdat       (rdat),
        .done       (done),
        .state      (state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [64:0]      exp_req_q[$];   // {we, adr, dat}
    logic [DAT_W-1:0] exp_rd_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- bus / slave model ----------------
    int               ack_wait     = 0;
    int               stall_target = 0;
    bit               stray_ack    = 1'b0;
    int               stall_seen   = 0;
    int               bm_cyc       = 0;
    int               due_q[$];
    logic [ADR_W-1:0] padr_q[$];
    logic [DAT_W-1:0] wq[$];

    initial begin
        logic             bm_acc;
        logic             bm_wfire;
        logic [ADR_W-1:0] bm_adr;
        wb_bus.ack   = 1'b0;
        wb_bus.stall = 1'b0;
        wb_bus.dat_i = '0;
        wdat_valid   = 1'b0;
        wdat         = '0;
        forever begin
            @(negedge clk);
            bm_acc   = wb_bus.cyc & wb_bus.stb & ~wb_bus.stall;
            bm_adr   = wb_bus.adr;
            bm_wfire = wdat_valid & wdat_ready;
            if (wb_bus.stb && wb_bus.stall) stall_seen++;
            @(posedge clk);
            #1;
            bm_cyc++;
            if (!rst) begin
                due_q.delete();
                padr_q.delete();
            end else if (bm_acc) begin
                due_q.push_back(bm_cyc + ack_wait);
                padr_q.push_back(bm_adr);
            end
            if (bm_wfire && wq.size() > 0) void'(wq.pop_front());
            wb_bus.ack   = stray_ack;
            wb_bus.dat_i = '0;
            if (rst && due_q.size() > 0 && due_q[0] <= bm_cyc) begin
                wb_bus.ack   = 1'b1;
                wb_bus.dat_i = padr_q[0] ^ RD_KEY;
                void'(due_q.pop_front());
                void'(padr_q.pop_front());
            end
            wb_bus.stall = (stall_seen < stall_target);
            wdat_valid   = (wq.size() > 0);
            wdat         = (wq.size() > 0) ? wq[0] : '0;
        end
    end

    // ---------------- monitor ----------------
    int               mcyc = 0;
    int               acc_total = 0, done_total = 0, cyc_total = 0;
    int               stall_total = 0, rdv_total = 0;
    int               cmd_cyc = 0, done_cyc = 0, first_acc_cyc = 0, last_acc_cyc = 0;
    int               max_out = 0, out_model = 0;
    bit               first_pend = 1'b0;
    logic             prev_hold = 1'b0;
    logic [ADR_W-1:0] prev_adr;
    logic [DAT_W-1:0] prev_dat;
    logic             prev_we;

    always @(negedge clk) begin
        logic        m_acc;
        logic        m_ack;
        logic [64:0] e;
        mcyc++;
        if (!rst) begin
            out_model = 0;
            prev_hold = 1'b0;
        end else begin
            m_acc = wb_bus.cyc & wb_bus.stb & ~wb_bus.stall;
            m_ack = wb_bus.ack & wb_bus.cyc & ((out_model > 0) | m_acc);
            if (cmd_valid && cmd_ready) begin
                cmd_cyc    = mcyc;
                first_pend = 1'b1;
                max_out    = 0;
            end
            if (wb_bus.cyc) cyc_total++;
            if (out_model == MAXO) check("stb_at_full", 64'(wb_bus.stb), 64'd0);
            if (wb_bus.stb && wb_bus.stall) begin
                stall_total++;
                check("wdat_ready_stalled", 64'(wdat_ready), 64'd0);
            end
            if (prev_hold && wb_bus.stb) begin
                check("hold_adr", 64'(wb_bus.adr), 64'(prev_adr));
                check("hold_dat", 64'(wb_bus.dat_o), 64'(prev_dat));
                check("hold_we", 64'(wb_bus.we), 64'(prev_we));
            end
            prev_hold = wb_bus.stb & wb_bus.stall;
            prev_adr  = wb_bus.adr;
            prev_dat  = wb_bus.dat_o;
            prev_we   = wb_bus.we;
            if (m_acc) begin
                acc_total++;
                last_acc_cyc = mcyc;
                if (first_pend) begin
                    first_acc_cyc = mcyc;
                    first_pend    = 1'b0;
                end
                if (exp_req_q.size() == 0) begin
                    check("req_unexpected", 64'(wb_bus.adr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_req_q.pop_front();
                    check("req_we", 64'(wb_bus.we), 64'(e[64]));
                    check("req_adr", 64'(wb_bus.adr), 64'(e[63:32]));
                    if (e[64]) check("req_dat", 64'(wb_bus.dat_o), 64'(e[31:0]));
                end
            end
            if (rdat_valid) begin
                rdv_total++;
                if (exp_rd_q.size() == 0) check("rdat_unexpected", 64'(rdat), 64'hFFFF_FFFF_FFFF_FFFF);
                else check("rdat", 64'(rdat), 64'(exp_rd_q.pop_front()));
            end
            out_model = out_model + int'(m_acc) - int'(m_ack);
            if (out_model > max_out) max_out = out_model;
            if (done) begin
                done_total++;
                done_cyc = mcyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic we, input logic [ADR_W-1:0] adr, input logic [LEN_W-1:0] len);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_len   = len;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
        end
        if (!ok) check("cmd_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int  d  = done_total;
        bit  ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (done_total != d) ok = 1'b1;
        end
        if (!ok) check(name, 64'd0, 64'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic push_read(input logic [ADR_W-1:0] adr, input logic [DAT_W-1:0] rd);
        exp_req_q.push_back({1'b0, adr, 32'h0});
        exp_rd_q.push_back(rd);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a0, d0, c0, s0, r0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_len   = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_cyc", 64'(wb_bus.cyc), 64'd0);
        check("rst_stb", 64'(wb_bus.stb), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_adr", 64'(wb_bus.adr), 64'd0);
        check("rst_state", 64'(state), 64'(ST_IDLE));
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // stray ack while idle is ignored
        stray_ack = 1'b1;
        @(negedge clk);
        check("stray_rdat_valid", 64'(rdat_valid), 64'd0);
        stray_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        // read 0x10 len 4, zero-wait slave
        a0 = acc_total; d0 = done_total; c0 = cyc_total; r0 = rdv_total;
        push_read(32'h10, 32'hA5A5_0010);
        push_read(32'h11, 32'hA5A5_0011);
        push_read(32'h12, 32'hA5A5_0012);
        push_read(32'h13, 32'hA5A5_0013);
        send_cmd(1'b0, 32'h10, 8'd4);
        wait_done("rd4_done_timeout");
        check("rd4_accepts", 64'(acc_total - a0), 64'd4);
        check("rd4_consecutive", 64'(last_acc_cyc - first_acc_cyc), 64'd3);
        check("rd4_latency", 64'(first_acc_cyc - cmd_cyc), 64'd1);
        check("rd4_cyc_cycles", 64'(cyc_total - c0), 64'd5);
        check("rd4_rdat_pulses", 64'(rdv_total - r0), 64'd4);
        check("rd4_done_count", 64'(done_total - d0), 64'd1);
        check("rd4_queues_empty", 64'(exp_req_q.size() + exp_rd_q.size()), 64'd0);

        // write 0x200 len 3, first request stalled 2 cycles
        a0 = acc_total; d0 = done_total; s0 = stall_total;
        wq.push_back(32'h1111_0001);
        wq.push_back(32'h1111_0002);
        wq.push_back(32'h1111_0003);
        exp_req_q.push_back({1'b1, 32'h200, 32'h1111_0001});
        exp_req_q.push_back({1'b1, 32'h201, 32'h1111_0002});
        exp_req_q.push_back({1'b1, 32'h202, 32'h1111_0003});
        stall_target = stall_seen + 2;
        send_cmd(1'b1, 32'h200, 8'd3);
        wait_done("wr3_done_timeout");
        check("wr3_stalled_cycles", 64'(stall_total - s0), 64'd2);
        check("wr3_accepts", 64'(acc_total - a0), 64'd3);
        check("wr3_words_consumed", 64'(wq.size()), 64'd0);
        check("wr3_done_count", 64'(done_total - d0), 64'd1);
        check("wr3_queue_empty", 64'(exp_req_q.size()), 64'd0);

        // read 0x40 len 4, slave withholds ack 5 cycles
        a0 = acc_total; d0 = done_total;
        ack_wait = 5;
        push_read(32'h40, 32'hA5A5_0040);
        push_read(32'h41, 32'hA5A5_0041);
        push_read(32'h42, 32'hA5A5_0042);
        push_read(32'h43, 32'hA5A5_0043);
        send_cmd(1'b0, 32'h40, 8'd4);
        wait_done("slow_done_timeout");
        check("slow_max_outstanding", 64'(max_out), 64'd2);
        check("slow_accepts", 64'(acc_total - a0), 64'd4);
        check("slow_done_count", 64'(done_total - d0), 64'd1);
        check("slow_queues_empty", 64'(exp_req_q.size() + exp_rd_q.size()), 64'd0);
        ack_wait = 0;

        // zero-length command
        a0 = acc_total; d0 = done_total; c0 = cyc_total;
        send_cmd(1'b0, 32'h300, 8'd0);
        wait_done("len0_done_timeout");
        check("len0_done_latency", 64'(done_cyc - cmd_cyc), 64'd1);
        check("len0_no_cyc", 64'(cyc_total - c0), 64'd0);
        check("len0_no_accepts", 64'(acc_total - a0), 64'd0);
        check("len0_done_count", 64'(done_total - d0), 64'd1);

        // address wrap
        push_read(32'hFFFF_FFFF, 32'h5A5A_FFFF);
        push_read(32'h0000_0000, 32'hA5A5_0000);
        send_cmd(1'b0, 32'hFFFF_FFFF, 8'd2);
        wait_done("wrap_done_timeout");
        check("wrap_queues_empty", 64'(exp_req_q.size() + exp_rd_q.size()), 64'd0);

        // reset mid-burst, then a fresh read
        a0 = acc_total;
        for (int i = 0; i < 8; i++) push_read(32'h500 + i, (32'h500 + i) ^ RD_KEY);
        send_cmd(1'b0, 32'h500, 8'd8);
        for (int i = 0; i < 100 && (acc_total - a0) < 3; i++) begin
            @(negedge clk);
            #1;
        end
        check("midburst_progress", 64'((acc_total - a0) >= 3), 64'd1);
        d0 = done_total;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort_cyc", 64'(wb_bus.cyc), 64'd0);
        check("abort_stb", 64'(wb_bus.stb), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
        exp_req_q.delete();
        exp_rd_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_release_ready", 64'(cmd_ready), 64'd1);
        check("abort_release_state", 64'(state), 64'(ST_IDLE));
        check("abort_no_done", 64'(done_total - d0), 64'd0);
        a0 = acc_total; d0 = done_total;
        push_read(32'h20, 32'hA5A5_0020);
        send_cmd(1'b0, 32'h20, 8'd1);
        wait_done("fresh_done_timeout");
        check("fresh_accepts", 64'(acc_total - a0), 64'd1);
        check("fresh_done_count", 64'(done_total - d0), 64'd1);
        check("fresh_queues_empty", 64'(exp_req_q.size() + exp_rd_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
